// File: rtl/fetch_queue.sv
// fetch_queue: dual-enqueue / in-order dual-dequeue instruction queue; define FETCH_QUEUE_STALL_CNT_EN to add the stall_cnt output
module fetch_queue #(
  parameter int DEPTH = 8,
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fetch_valid,
  input  logic [3:0]    pc1,
  input  logic [3:0]    pc2,
  input  logic [IW-1:0] instr1,
  input  logic [IW-1:0] instr2,
  output logic          stall,
  input  logic          flush,
  input  logic          issue_ready1,
  input  logic          issue_ready2,
  output logic          out_valid1,
  output logic          out_valid2,
  output logic [3:0]    out_pc1,
  output logic [3:0]    out_pc2,
  output logic [IW-1:0] out_instr1,
  output logic [IW-1:0] out_instr2
`ifdef FETCH_QUEUE_STALL_CNT_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [3:0]    pc_mem    [DEPTH];
  logic [IW-1:0] instr_mem [DEPTH];
  logic [AW-1:0] head, tail, head1, tail1, head_next, tail_next;
  logic [CW-1:0] count, count_next;
  logic          enq, pop1, pop2;
  // Occupancy decode from registered count, in-order pop selection, next-state arithmetic and masked read-out
  always_comb begin
    head1      = head + AW'(1);
    tail1      = tail + AW'(1);
    stall      = count > CW'(DEPTH - 2);
    out_valid1 = count >= CW'(1);
    out_valid2 = count >= CW'(2);
    enq        = fetch_valid & ~stall;
    pop1       = out_valid1 & issue_ready1;
    pop2       = pop1 & out_valid2 & issue_ready2;
    head_next  = head + (pop2 ? AW'(2) : pop1 ? AW'(1) : AW'(0));
    tail_next  = tail + (enq ? AW'(2) : AW'(0));
    count_next = count + (enq ? CW'(2) : CW'(0)) - CW'(pop1) - CW'(pop2);
    out_pc1    = out_valid1 ? pc_mem[head] : 4'd0;
    out_pc2    = out_valid2 ? pc_mem[head1] : 4'd0;
    out_instr1 = out_valid1 ? instr_mem[head] : '0;
    out_instr2 = out_valid2 ? instr_mem[head1] : '0;
  end
  // Pointers and occupancy; reset beats flush, flush beats any same-cycle enqueue or dequeue
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end
  // Payload array needs no reset: slots beyond count are masked on read
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail]     <= pc1;
      instr_mem[tail]  <= instr1;
      pc_mem[tail1]    <= pc2;
      instr_mem[tail1] <= instr2;
    end
  end
`ifdef FETCH_QUEUE_STALL_CNT_EN
  // Saturating count of fetch cycles turned away by stall; only reset clears it
  always_ff @(posedge clk) begin
    if (!reset) stall_cnt <= '0;
    else if (stall && fetch_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard queue checked by an independent dequeue monitor
module tb_fetch_queue;
  logic        clk = 1'b0, reset = 1'b0, fetch_valid = 1'b0, flush = 1'b0;
  logic        issue_ready1 = 1'b0, issue_ready2 = 1'b0;
  logic [3:0]  pc1 = 4'd0, pc2 = 4'd0;
  logic [15:0] instr1 = 16'd0, instr2 = 16'd0;
  logic        stall, out_valid1, out_valid2;
  logic [3:0]  out_pc1, out_pc2;
  logic [15:0] out_instr1, out_instr2;
`ifdef FETCH_QUEUE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  typedef struct {
    logic [3:0]  pc;
    logic [15:0] instr;
  } ent_t;
  ent_t exp_q[$];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(8), .IW(16)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid),
    .pc1(pc1), .pc2(pc2), .instr1(instr1), .instr2(instr2),
    .stall(stall), .flush(flush),
    .issue_ready1(issue_ready1), .issue_ready2(issue_ready2),
    .out_valid1(out_valid1), .out_valid2(out_valid2),
    .out_pc1(out_pc1), .out_pc2(out_pc2),
    .out_instr1(out_instr1), .out_instr2(out_instr2)
`ifdef FETCH_QUEUE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: pair at p/p+1 with instr = A001+pc; acc says whether the pair is expected to be stored
  task automatic drive(input logic fv, input logic [3:0] p, input logic [1:0] ir, input logic fl, input logic acc);
    fetch_valid = fv;
    pc1 = p;
    pc2 = p + 4'd1;
    instr1 = 16'hA001 + 16'(p);
    instr2 = 16'hA001 + 16'(pc2);
    {issue_ready1, issue_ready2} = ir;
    flush = fl;
    if (acc) begin
      exp_q.push_back('{pc: pc1, instr: instr1});
      exp_q.push_back('{pc: pc2, instr: instr2});
    end
    @(posedge clk);
    #1;
    fetch_valid = 1'b0;
    {issue_ready1, issue_ready2} = 2'b00;
    flush = 1'b0;
  endtask

  // Monitor: whenever a slot is about to be issued, it must match the oldest expected entry
  always @(negedge clk) begin
    if (reset && !flush && out_valid1 && issue_ready1) begin
      ent_t e;
      if (exp_q.size() == 0) chk("pop1_underflow", 32'(out_pc1), 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("pop1_pc", 32'(out_pc1), 32'(e.pc));
        chk("pop1_instr", 32'(out_instr1), 32'(e.instr));
      end
      if (out_valid2 && issue_ready2) begin
        if (exp_q.size() == 0) chk("pop2_underflow", 32'(out_pc2), 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("pop2_pc", 32'(out_pc2), 32'(e.pc));
          chk("pop2_instr", 32'(out_instr2), 32'(e.instr));
        end
      end
    end
  end

  initial begin
    logic [3:0] p;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_valid", 32'({out_valid1, out_valid2}), 0);
    chk("rst_pc", 32'({out_pc1, out_pc2}), 0);
    chk("rst_instr", {out_instr1, out_instr2}, 0);
`ifdef FETCH_QUEUE_STALL_CNT_EN
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
    drive(1'b1, 4'd0, 2'b00, 1'b0, 1'b1);
    chk("pair_valid", 32'({out_valid1, out_valid2}), 3);
    chk("pair_pc1", 32'(out_pc1), 0);
    chk("pair_pc2", 32'(out_pc2), 1);
    chk("pair_instr", {out_instr1, out_instr2}, 32'hA001_A002);
    chk("pair_stall", 32'(stall), 0);
    drive(1'b0, 4'd0, 2'b01, 1'b0, 1'b0);
    chk("slot2_alone_valid", 32'({out_valid1, out_valid2}), 3);
    chk("slot2_alone_pc1", 32'(out_pc1), 0);
    drive(1'b0, 4'd0, 2'b11, 1'b0, 1'b0);
    chk("both_pop_empty", 32'({out_valid1, out_valid2}), 0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'(2 + 2 * k), 2'b00, 1'b0, 1'b1);
      chk("fill_stall", 32'(stall), 32'(k == 3));
    end
    repeat (3) begin
      drive(1'b1, 4'd10, 2'b00, 1'b0, 1'b0);
      chk("full_stall", 32'(stall), 1);
    end
    chk("full_pc1", 32'(out_pc1), 2);
    chk("full_pc2", 32'(out_pc2), 3);
`ifdef FETCH_QUEUE_STALL_CNT_EN
    chk("stall_cnt3", 32'(stall_cnt), 3);
`endif
    drive(1'b0, 4'd0, 2'b10, 1'b0, 1'b0);
    chk("cnt7_stall", 32'(stall), 1);
    chk("cnt7_pc1", 32'(out_pc1), 3);
    drive(1'b1, 4'd12, 2'b11, 1'b0, 1'b0);
    chk("cnt5_stall", 32'(stall), 0);
    chk("cnt5_pc1", 32'(out_pc1), 5);
    repeat (3) drive(1'b0, 4'd0, 2'b11, 1'b0, 1'b0);
    chk("drain_valid", 32'({out_valid1, out_valid2}), 0);
    p = 4'd0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, p, 2'b11, 1'b0, 1'b1);
      chk("wrap_stall", 32'(stall), 0);
      p += 4'd2;
    end
    drive(1'b0, 4'd0, 2'b11, 1'b0, 1'b0);
    chk("wrap_drain", 32'({out_valid1, out_valid2}), 0);
    for (int k = 0; k < 3; k++) drive(1'b1, 4'(2 * k), 2'b00, 1'b0, 1'b1);
    chk("cnt6_stall", 32'(stall), 0);
    drive(1'b1, 4'd6, 2'b11, 1'b1, 1'b0);
    exp_q.delete();
    chk("flush_valid", 32'({out_valid1, out_valid2}), 0);
    chk("flush_stall", 32'(stall), 0);
    chk("flush_pc", 32'({out_pc1, out_pc2}), 0);
    drive(1'b1, 4'd8, 2'b00, 1'b0, 1'b1);
    chk("post_flush_pc", 32'({out_pc1, out_pc2}), 32'h89);
    drive(1'b0, 4'd0, 2'b11, 1'b0, 1'b0);
    chk("sb_empty", 32'(exp_q.size()), 0);
    drive(1'b1, 4'd10, 2'b00, 1'b0, 1'b1);
    reset = 1'b0;
    drive(1'b1, 4'd12, 2'b11, 1'b0, 1'b0);
    reset = 1'b1;
    exp_q.delete();
    chk("midrst_valid", 32'({out_valid1, out_valid2}), 0);
    chk("midrst_stall", 32'(stall), 0);
    chk("midrst_pc", 32'({out_pc1, out_pc2}), 0);
`ifdef FETCH_QUEUE_STALL_CNT_EN
    chk("midrst_stall_cnt", 32'(stall_cnt), 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries (power of two, >=4).
REQ-002 SHALL have parameter IW, default 16, instruction word width.
REQ-003 SHALL have one clock; reset is synchronous and active-low: clk  input  1  rising-edge clock.
REQ-004 SHALL have reset  input  1  synchronous active-low reset (0 = reset).
REQ-005 SHALL have fetch_valid  input  1  pair (pc1/instr1, pc2/instr2) presented this cycle.
REQ-006 SHALL have pc1, pc2  input  4  PCs of the older and younger fetched instruction.
REQ-007 SHALL have instr1, instr2  input  IW  instruction words read at pc1, pc2.
REQ-008 SHALL have stall  output  1  to fetch stage; 1 = pair not accepted, hold PCs.
REQ-009 SHALL have flush  input  1  discard all queued entries (mispredict/redirect).
REQ-010 SHALL have issue_ready1, issue_ready2  input  1 each  issue slot 1/2 can take an instruction.
REQ-011 SHALL have out_valid1, out_valid2  output  1 each  head / head+1 entry valid.
REQ-012 SHALL have out_pc1, out_pc2  output  4 each; out_instr1, out_instr2  output  IW each  head / head+1 contents.

Function
REQ-013 SHALL store entries {pc, instr} in a circular buffer with head, tail pointers wrapping modulo DEPTH and count 0..DEPTH.
REQ-014 SHALL drive stall = 1 exactly when count > DEPTH-2, from registered count only (no same-cycle dequeue credit).
REQ-015 SHALL enqueue both entries (pc1 at tail, pc2 at tail+1) when fetch_valid=1 and stall=0; never enqueue one of a pair.
REQ-016 SHALL drive out_valid1 = (count>=1), out_valid2 = (count>=2); out_pc/out_instr of an invalid slot SHALL read 0.
REQ-017 SHALL dequeue in order: pop1 = out_valid1 & issue_ready1; pop2 = pop1 & out_valid2 & issue_ready2; slot 2 never pops alone.
REQ-018 SHALL update count_next = count + 2*enq - pop1 - pop2 when enq and pops occur in the same cycle.
REQ-019 SHALL make enqueued entries visible at outputs the cycle after enqueue (1-cycle latency, no empty bypass).
REQ-020 SHALL, on flush=1, set head=tail=count=0 next cycle, ignore same-cycle enqueue and dequeue, and treat nothing as issued.
REQ-021 SHALL keep stall a function of count only, so stall is 0 in the cycle after flush.

Reset
REQ-022 SHALL, while reset=0 at a rising edge, clear head, tail, count; outputs next cycle: stall=0, out_valid1/2=0, out_pc1/2=0, out_instr1/2=0.
REQ-023 SHALL let reset override flush, fetch_valid and issue_ready; reset mid-operation discards all entries.
REQ-024 SHALL need no storage-array reset; invalid slots are masked per REQ-016.

Configuration
REQ-025 SHALL, with macro FETCH_QUEUE_STALL_CNT_EN defined, add output stall_cnt (16 bits) counting cycles with stall=1 & fetch_valid=1, saturating at 16'hFFFF, cleared by reset only.
REQ-026 SHALL, without FETCH_QUEUE_STALL_CNT_EN, omit the stall_cnt port and counter; all other behaviour identical.

Verification
REQ-027 SHALL cover: reset, one pair pc1=0/pc2=1, instr 16'hA001/16'hA002, issue_ready=00 -> next cycle out_valid=11, out_pc1=0, out_pc2=1, count=2.
REQ-028 SHALL cover: DEPTH=8, 4 pairs, no issue -> stall=1 from count=8 onward (stall at count 7 too); 5th pair not stored, out_pc1 still 0.
REQ-029 SHALL cover: count=2, issue_ready1=0, issue_ready2=1 -> no pop, count stays 2; issue_ready=11 -> both pop, count 0.
REQ-030 SHALL cover: count=7 (stall=1), issue_ready=11, fetch_valid=1 -> pair rejected, count=5 next cycle, stall=0.
REQ-031 SHALL cover: >4 enqueue/dequeue wraps of head/tail at DEPTH=8 -> PC order preserved across wrap-around.
REQ-032 SHALL cover: flush=1 with fetch_valid=1, count=6 -> next cycle out_valid=00, stall=0; with FETCH_QUEUE_STALL_CNT_EN, 3 stalled fetch cycles -> stall_cnt=3.
